// File: rtl/wb_rom_loader.sv
// Byte-stream to Wishbone classic loader: packs little-endian bytes into 32-bit
// words, writes them to consecutive addresses and optionally reads each back to compare.
module wb_rom_loader #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic        verify,
    input  logic [31:0] base_addr,
    input  logic [9:0]  word_count,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        READ,
        FINISH
    } state_t;

    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT - 1);
    localparam logic [9:0] MAX_WORDS    = 10'd512;

    state_t      state;
    logic [31:0] base_q;
    logic [9:0]  count_q;
    logic        verify_q;
    logic [9:0]  index;
    logic [1:0]  byte_cnt;
    logic [23:0] word_q;
    logic [9:0]  timer;

    logic        last_word;
    logic        timed_out;
    logic [31:0] word_addr;

    assign last_word = (index + 10'd1) == count_q;
    assign timed_out = timer == TIMEOUT_LAST;
    // Address arithmetic deliberately wraps at 2^32.
    assign word_addr = base_q + {20'd0, index, 2'b00};

    // NOTE: every register here, including the datapath ones, is cleared by the
    // synchronous reset so a reset mid-transfer leaves no stale word or address.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            verify_q   <= 1'b0;
            index      <= '0;
            byte_cnt   <= '0;
            word_q     <= '0;
            timer      <= '0;
            byte_ready <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            wbm_sel_o  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        base_q   <= base_addr & 32'hFFFF_FFFC;
                        count_q  <= (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
                        verify_q <= verify;
                        index    <= '0;
                        byte_cnt <= '0;
                        if (word_count == 10'd0) begin
                            state <= FINISH;
                        end else begin
                            state      <= COLLECT;
                            byte_ready <= 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (byte_valid && byte_ready) begin
                        word_q   <= {byte_data, word_q[23:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            byte_ready <= 1'b0;
                            state      <= WRITE;
                            wbm_cyc_o  <= 1'b1;
                            wbm_stb_o  <= 1'b1;
                            wbm_we_o   <= 1'b1;
                            wbm_sel_o  <= 4'hF;
                            wbm_adr_o  <= word_addr;
                            wbm_dat_o  <= {byte_data, word_q};
                            timer      <= '0;
                        end
                    end
                end

                WRITE: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= '0;
                        if (verify_q) begin
                            state <= READ;
                        end else if (last_word) begin
                            state <= FINISH;
                        end else begin
                            index      <= index + 10'd1;
                            state      <= COLLECT;
                            byte_ready <= 1'b1;
                        end
                    end else if (timed_out) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= '0;
                        error     <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        timer <= timer + 10'd1;
                    end
                end

                // First READ cycle is the mandatory idle gap after the write.
                READ: begin
                    if (!wbm_cyc_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= 4'hF;
                        timer     <= '0;
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_sel_o <= '0;
                        if (wbm_dat_i != wbm_dat_o) begin
                            error <= 1'b1;
                            state <= FINISH;
                        end else if (last_word) begin
                            state <= FINISH;
                        end else begin
                            index      <= index + 10'd1;
                            state      <= COLLECT;
                            byte_ready <= 1'b1;
                        end
                    end else if (timed_out) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_sel_o <= '0;
                        error     <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        timer <= timer + 10'd1;
                    end
                end

                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rom_loader.sv
// Directed bench for wb_rom_loader: table of load scenarios checked against a
// word/address model, plus hand-written timeout, zero-count and reset sequences.
module tb_wb_rom_loader;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        verify = 1'b0;
    logic [31:0] base_addr = '0;
    logic [9:0]  word_count = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;
    logic        busy, done, error;

    always #5 clk = ~clk;

    wb_rom_loader #(.TIMEOUT(TMO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .start      (start),
        .verify     (verify),
        .base_addr  (base_addr),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Byte source: only the always block advances the pointer; loads index relative to ptr_base.
    logic [7:0] cur_bytes [$];
    int   src_ptr  = 0;
    int   ptr_base = 0;
    logic src_en   = 1'b0;
    logic src_rand = 1'b0;

    always @(posedge clk)
        if (!rst && byte_valid && byte_ready) src_ptr <= src_ptr + 1;

    always @(negedge clk) begin : drive_bytes
        int rel;
        rel = src_ptr - ptr_base;
        if (src_en && rel < cur_bytes.size()) begin
            byte_data  = cur_bytes[rel];
            byte_valid = !src_rand || ($urandom_range(0, 1) == 1);
        end else begin
            byte_data  = 8'h00;
            byte_valid = 1'b0;
        end
    end

    // Wishbone responder with programmable wait states and a transaction log.
    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_t;

    bus_t        log_q [$];
    int          log_base = 0;
    logic        never_ack = 1'b0;
    logic        rd_bad = 1'b0;
    int          max_delay = 0;
    int          wait_cnt = 0;
    int          ack_delay = 0;
    logic [31:0] last_wdata = '0;
    logic        proto_err = 1'b0;
    logic        held_valid = 1'b0;
    logic        ack_prev = 1'b0;
    bus_t        held;

    assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && !never_ack && (wait_cnt == ack_delay);
    assign wbm_dat_i = rd_bad ? 32'hDEAD_BEEF : last_wdata;

    always @(posedge clk) begin
        if (rst || !(wbm_cyc_o && wbm_stb_o)) begin
            wait_cnt <= 0;
        end else if (wbm_ack_i) begin
            wait_cnt  <= 0;
            ack_delay <= $urandom_range(0, max_delay);
        end else begin
            wait_cnt <= wait_cnt + 1;
        end

        if (!rst && wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
            log_q.push_back('{we: wbm_we_o, adr: wbm_adr_o, dat: (wbm_we_o ? wbm_dat_o : 32'h0)});
            if (wbm_we_o) last_wdata <= wbm_dat_o;
        end

        // Bus outputs must hold while waiting, cycles must be separated, sel must be full.
        if (!rst && held_valid && wbm_cyc_o && wbm_stb_o &&
            (held != {wbm_we_o, wbm_adr_o, wbm_dat_o})) proto_err <= 1'b1;
        if (!rst && ack_prev && wbm_cyc_o) proto_err <= 1'b1;
        if (!rst && wbm_cyc_o && wbm_sel_o != 4'hF) proto_err <= 1'b1;
        held       <= {wbm_we_o, wbm_adr_o, wbm_dat_o};
        held_valid <= !rst && wbm_cyc_o && wbm_stb_o && !wbm_ack_i;
        ack_prev   <= !rst && wbm_cyc_o && wbm_stb_o && wbm_ack_i;
    end

    typedef struct {
        logic [31:0] base;
        logic [9:0]  count;
        logic        verify;
        logic        rd_bad;
        logic        rand_valid;
        int          max_delay;
        logic [7:0]  seed;
        int          poke_cycle;
        logic        exp_error;
        int          exp_cycles;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v, input int vi);
        logic [7:0] bytes [$];
        bus_t       exp_q [$];
        bus_t       e;
        int         n, done_cnt, done_at, got;
        logic       saw_cyc, saw_ready;
        string      tag;

        tag = $sformatf("v%0d", vi);
        n = (v.count > 10'd512) ? 512 : int'(v.count);
        for (int k = 0; k < 4 * n; k++) bytes.push_back(8'(v.seed + 8'(17 * (k + 1))));
        for (int i = 0; i < n; i++) begin
            e.we  = 1'b1;
            e.adr = (v.base & 32'hFFFF_FFFC) + 32'(4 * i);
            e.dat = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
            exp_q.push_back(e);
            if (v.verify) begin
                e.we  = 1'b0;
                e.dat = 32'h0;
                exp_q.push_back(e);
                if (v.rd_bad) break;
            end
        end

        @(negedge clk);
        cur_bytes  = bytes;
        ptr_base   = src_ptr;
        log_base   = log_q.size();
        src_rand   = v.rand_valid;
        max_delay  = v.max_delay;
        rd_bad     = v.rd_bad;
        never_ack  = 1'b0;
        src_en     = 1'b1;
        start      = 1'b1;
        base_addr  = v.base;
        word_count = v.count;
        verify     = v.verify;

        done_cnt  = 0;
        done_at   = -1;
        saw_cyc   = 1'b0;
        saw_ready = 1'b0;
        for (int c = 1; c < 20000; c++) begin
            @(negedge clk);
            if (c == v.poke_cycle) begin
                start      = 1'b1;
                base_addr  = 32'h5555_0000;
                word_count = 10'd9;
                verify     = ~v.verify;
            end else begin
                start      = 1'b0;
                base_addr  = ~v.base;
                word_count = 10'd7;
                verify     = ~v.verify;
            end
            if (c == 1) begin
                check({tag, "_busy_after_start"}, busy, 1);
                check({tag, "_error_cleared"}, error, 0);
            end
            saw_cyc   = saw_cyc | wbm_cyc_o;
            saw_ready = saw_ready | byte_ready;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (done_at >= 0 && c >= done_at + 3) break;
        end
        start = 1'b0;

        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_error"}, error, v.exp_error);
        check({tag, "_busy_idle"}, busy, 0);
        got = log_q.size() - log_base;
        check({tag, "_bus_cycles"}, got, v.exp_cycles);
        for (int i = 0; i < exp_q.size() && i < got; i++) begin
            check($sformatf("%s_adr%0d", tag, i), log_q[log_base+i].adr, exp_q[i].adr);
            check($sformatf("%s_we_dat%0d", tag, i),
                  {log_q[log_base+i].we, log_q[log_base+i].dat}, {exp_q[i].we, exp_q[i].dat});
        end
        check({tag, "_protocol"}, proto_err, 0);
        if (v.count == 10'd0) begin
            check({tag, "_zero_done_latency"}, done_at, 2);
            check({tag, "_zero_no_cyc"}, saw_cyc, 0);
            check({tag, "_zero_no_ready"}, saw_ready, 0);
        end
        src_en = 1'b0;
    endtask

    task automatic timeout_seq();
        int c_on, c_off;
        c_on  = -1;
        c_off = -1;
        @(negedge clk);
        cur_bytes  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        ptr_base   = src_ptr;
        log_base   = log_q.size();
        src_rand   = 1'b0;
        never_ack  = 1'b1;
        src_en     = 1'b1;
        start      = 1'b1;
        base_addr  = 32'h0000_8000;
        word_count = 10'd1;
        verify     = 1'b0;
        for (int c = 1; c <= 200 && c_off < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c_on < 0 && wbm_cyc_o) c_on = c;
            else if (c_on >= 0 && !wbm_cyc_o) c_off = c;
        end
        check("tmo_cyc_dropped", c_off >= 0, 1);
        check("tmo_cyc_len", c_off - c_on, TMO);
        check("tmo_error_at_drop", error, 1);
        check("tmo_stb_at_drop", wbm_stb_o, 0);
        @(negedge clk);
        check("tmo_done", done, 1);
        check("tmo_busy_after", busy, 0);
        @(negedge clk);
        check("tmo_done_once", done, 0);
        check("tmo_error_held", error, 1);
        check("tmo_no_ack_logged", log_q.size() - log_base, 0);
        never_ack = 1'b0;
        src_en    = 1'b0;
    endtask

    task automatic reset_seq();
        logic found;
        found = 1'b0;
        @(negedge clk);
        cur_bytes  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        ptr_base   = src_ptr;
        log_base   = log_q.size();
        src_rand   = 1'b0;
        never_ack  = 1'b1;
        src_en     = 1'b1;
        start      = 1'b1;
        base_addr  = 32'h0000_2000;
        word_count = 10'd2;
        verify     = 1'b0;
        for (int c = 1; c <= 100 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            found = wbm_cyc_o;
        end
        check("rst_write_reached", found, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        src_en = 1'b0;
        check("rst_mid_ctrl",
              {byte_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy, done, error}, 0);
        check("rst_mid_adr", wbm_adr_o, 0);
        check("rst_mid_dat", wbm_dat_o, 0);
        repeat (3) @(negedge clk);
        check("rst_stays_idle", {busy, wbm_cyc_o, byte_ready}, 0);
        never_ack = 1'b0;
    endtask

    initial begin
        vecs[0] = '{base: 32'h3000_0000, count: 10'd2,    verify: 0, rd_bad: 0, rand_valid: 0,
                    max_delay: 0, seed: 8'h00, poke_cycle: -1, exp_error: 0, exp_cycles: 2};
        vecs[1] = '{base: 32'h1000_0010, count: 10'd1,    verify: 1, rd_bad: 0, rand_valid: 0,
                    max_delay: 0, seed: 8'h40, poke_cycle: -1, exp_error: 0, exp_cycles: 2};
        vecs[2] = '{base: 32'h1000_0010, count: 10'd1,    verify: 1, rd_bad: 1, rand_valid: 0,
                    max_delay: 0, seed: 8'h40, poke_cycle: -1, exp_error: 1, exp_cycles: 2};
        vecs[3] = '{base: 32'hFFFF_FFF9, count: 10'd4,    verify: 0, rd_bad: 0, rand_valid: 1,
                    max_delay: 5, seed: 8'h03, poke_cycle: -1, exp_error: 0, exp_cycles: 4};
        vecs[4] = '{base: 32'h0000_1000, count: 10'd3,    verify: 1, rd_bad: 0, rand_valid: 1,
                    max_delay: 5, seed: 8'h5A, poke_cycle: 5,  exp_error: 0, exp_cycles: 6};
        vecs[5] = '{base: 32'h2000_0000, count: 10'd0,    verify: 0, rd_bad: 0, rand_valid: 0,
                    max_delay: 0, seed: 8'h00, poke_cycle: -1, exp_error: 0, exp_cycles: 0};
        vecs[6] = '{base: 32'h4000_0000, count: 10'd1000, verify: 0, rd_bad: 0, rand_valid: 0,
                    max_delay: 0, seed: 8'h77, poke_cycle: -1, exp_error: 0, exp_cycles: 512};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ctrl",
              {byte_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy, done, error}, 0);
        check("reset_adr", wbm_adr_o, 0);
        check("reset_dat", wbm_dat_o, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
        timeout_seq();
        reset_seq();
        run_vec(vecs[0], 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_rom_loader.md
WB_ROM_LOADER -- requirements
Module: wb_rom_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for wbm_ack_i per bus cycle (1..1023).
REQ-002 SHALL have port wb_clk_i, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: one-cycle pulse that begins a load.
REQ-005 SHALL have port verify, input, 1: readback-compare enable, sampled on start.
REQ-006 SHALL have port base_addr, input, 32: byte address of word 0, sampled on start, bits [1:0] ignored.
REQ-007 SHALL have port word_count, input, 10: number of words (0..512), sampled on start; values >512 clamp to 512.
REQ-008 SHALL have port byte_valid, input, 1: byte stream valid.
REQ-009 SHALL have port byte_data, input, 8: byte stream data.
REQ-010 SHALL have port byte_ready, output, 1: byte accepted when byte_valid && byte_ready.
REQ-011 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o, output, 1 each: Wishbone classic initiator controls.
REQ-012 SHALL have port wbm_adr_o, output, 32: bus address.
REQ-013 SHALL have port wbm_dat_o, output, 32: write data.
REQ-014 SHALL have port wbm_sel_o, output, 4: byte lanes, always 4'hF during a cycle.
REQ-015 SHALL have port wbm_dat_i, input, 32: read data.
REQ-016 SHALL have port wbm_ack_i, input, 1: responder acknowledge.
REQ-017 SHALL have ports busy, done and error, output, 1 each: status.

Function
REQ-018 SHALL implement the states IDLE, COLLECT, WRITE, READ, FINISH.
REQ-019 IDLE: start moves to COLLECT and clears done and error; with word_count==0 it moves to FINISH instead, and no bus cycle occurs.
REQ-020 COLLECT: byte_ready=1; four accepted bytes form a word, little-endian (first byte -> [7:0]); on the 4th byte move to WRITE the next cycle.
REQ-021 WRITE: cyc=stb=we=1, adr=base+4*index, dat=word; hold all bus outputs stable until ack is sampled high.
REQ-022 A bus cycle SHALL deassert cyc/stb on the edge on which ack is sampled, giving at least one idle cycle between bus cycles.
REQ-023 After a write ack: with verify=1 go to READ; otherwise increment index, then go to COLLECT, or to FINISH if index+1==word_count.
REQ-024 READ: cyc=stb=1, we=0, same address; on ack compare wbm_dat_i with the word; a mismatch sets error and goes to FINISH; a match advances as in REQ-023.
REQ-025 The ack timeout counter SHALL reset at each cycle start; reaching TIMEOUT without ack drops cyc/stb, sets error and goes to FINISH.
REQ-026 FINISH SHALL pulse done for exactly 1 cycle, then return to IDLE; error SHALL hold until the next start or reset.
REQ-027 busy=1 in every state except IDLE; start SHALL be ignored while busy.
REQ-028 byte_ready SHALL be 0 outside COLLECT; bytes presented then are not consumed.
REQ-029 The word index SHALL be 10 bits; the address SHALL be computed modulo 2^32 (wraps).

Reset
REQ-030 On wb_rst_i: state=IDLE; cyc, stb, we, byte_ready, busy, done and error=0; adr, dat_o and sel=0; index, byte counter and timeout cleared.
REQ-031 Reset asserted mid-bus-cycle SHALL drop cyc/stb on that edge; the partial word is discarded.

Verification
REQ-032 base=0x3000_0000, count=2, verify=0, bytes 11 22 33 44 55 66 77 88, zero-wait ack -> writes 0x44332211@0x30000000, 0x88776655@0x30000004, one done pulse, error=0.
REQ-033 count=1, verify=1, responder echoes data -> a write then a read at the same address, done=1, error=0; repeat with read returning 0xDEADBEEF -> error=1 after the read ack.
REQ-034 TIMEOUT=8, responder never acks -> cyc drops 8 cycles after assertion, error=1, done pulses, busy=0 the next cycle.
REQ-035 count=0 -> done pulses 2 cycles after start, cyc is never asserted, byte_ready stays 0.
REQ-036 byte_valid toggled randomly, ack delayed 0-5 cycles, start pulsed while busy, reset asserted during WRITE -> the assembled data and addresses match the model; the extra start is ignored; all outputs are 0 the cycle after reset.
